// File: rtl/button_cmd_filter_if.sv
// Button filter bus: raw pads in, debounced levels and press strobes out.
// The filter side uses the slave modport; the pad/driver side uses master.
interface button_cmd_filter_if #(
    parameter int unsigned N_BTN = 3
);
    logic [N_BTN-1:0] i_btn_raw;
    logic [N_BTN-1:0] o_btn_level;
    logic [N_BTN-1:0] o_cmd_pulse;

    modport master (
        output i_btn_raw,
        input  o_btn_level,
        input  o_cmd_pulse
    );

    modport slave (
        input  i_btn_raw,
        output o_btn_level,
        output o_cmd_pulse
    );
endinterface

// File: rtl/button_cmd_filter.sv
// Per-channel 2-FF synchroniser, stability-counter debouncer and registered
// one-cycle press strobe for the board push-buttons.
module button_cmd_filter #(
    parameter int unsigned N_BTN           = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    button_cmd_filter_if.slave btn
);
    localparam int unsigned     CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [N_BTN-1:0] IDLE_PAD = {N_BTN{ACTIVE_LOW}};

    if (N_BTN < 1) begin : g_bad_n_btn
        $error("button_cmd_filter: N_BTN must be >= 1");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("button_cmd_filter: DEBOUNCE_CYCLES must be >= 1");
    end

    logic [N_BTN-1:0] sync1_q, sync2_q;
    logic [N_BTN-1:0] pressed_sync;
    logic [N_BTN-1:0] stable_q, stable_d;
    logic [N_BTN-1:0] pulse_q, pulse_d;
    logic [CW-1:0]    cnt_q [N_BTN];
    logic [CW-1:0]    cnt_d [N_BTN];

    assign pressed_sync = sync2_q ^ IDLE_PAD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= IDLE_PAD;
            sync2_q  <= IDLE_PAD;
            stable_q <= '0;
            pulse_q  <= '0;
            for (int unsigned i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= btn.i_btn_raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
            for (int unsigned i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // A matching sample or a commit clears the counter, so it never wraps.
    always_comb begin
        stable_d = stable_q;
        pulse_d  = '0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            cnt_d[i] = '0;
            if (pressed_sync[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = pressed_sync[i];
                    pulse_d[i]  = pressed_sync[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign btn.o_btn_level = stable_q;
    assign btn.o_cmd_pulse = pulse_q;
endmodule

// File: tb/tb_button_cmd_filter.sv
// Bench for button_cmd_filter: directed timing cases plus random pad activity
// compared against a sliding-window debounce model, both pad polarities.
module tb_button_cmd_filter;
    localparam int unsigned N = 3;
    localparam int unsigned D = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] press = '0;

    button_cmd_filter_if #(.N_BTN(N)) bif_lo ();
    button_cmd_filter_if #(.N_BTN(N)) bif_hi ();

    assign bif_lo.i_btn_raw = ~press;
    assign bif_hi.i_btn_raw = press;

    button_cmd_filter #(.N_BTN(N), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1)) dut_lo (
        .clk(clk), .rst_n(rst_n), .btn(bif_lo.slave));
    button_cmd_filter #(.N_BTN(N), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b0)) dut_hi (
        .clk(clk), .rst_n(rst_n), .btn(bif_hi.slave));

    int checks = 0;
    int errors = 0;

    // Model: a level is accepted once the last D synchronised samples all
    // disagree with the current accepted level.
    logic [N-1:0] m_s1, m_s2, m_stable, m_pulse;
    logic [N-1:0] win [D];

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_stable = '0; m_pulse = '0;
        for (int k = 0; k < int'(D); k++) win[k] = '0;
    endtask

    task automatic model_edge();
        logic [N-1:0] p;
        logic all_diff;
        p = m_s2;
        for (int k = int'(D) - 1; k > 0; k--) win[k] = win[k-1];
        win[0] = p;
        m_pulse = '0;
        for (int c = 0; c < int'(N); c++) begin
            all_diff = 1'b1;
            for (int k = 0; k < int'(D); k++)
                if (win[k][c] == m_stable[c]) all_diff = 1'b0;
            if (all_diff) begin
                m_stable[c] = ~m_stable[c];
                m_pulse[c]  = m_stable[c];
                // window now matches the new level, so restart acceptance
                for (int k = 0; k < int'(D); k++) win[k][c] = m_stable[c];
            end
        end
        m_s2 = m_s1;
        m_s1 = press;
    endtask

    task automatic cycle(input logic [N-1:0] pr);
        press = pr;
        @(posedge clk);
        model_edge();
        #1;
        chk("lvl_lo", bif_lo.o_btn_level, m_stable);
        chk("pls_lo", bif_lo.o_cmd_pulse, m_pulse);
        chk("lvl_hi", bif_hi.o_btn_level, m_stable);
        chk("pls_hi", bif_hi.o_cmd_pulse, m_pulse);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle('0);
    endtask

    initial begin
        int npulse;
        model_reset();
        press = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_lvl", bif_lo.o_btn_level, '0);
        chk("reset_pls", bif_lo.o_cmd_pulse, '0);
        chk("reset_lvl_hi", bif_hi.o_btn_level, '0);
        rst_n = 1'b1;
        idle(4);

        // Press latency: level and strobe after E6, strobe gone after E7.
        for (int e = 1; e <= 7; e++) begin
            cycle(3'b001);
            if (e == 5) chk("press_e5_lvl", bif_lo.o_btn_level, 3'b000);
            if (e == 6) begin
                chk("press_e6_lvl", bif_lo.o_btn_level, 3'b001);
                chk("press_e6_pls", bif_lo.o_cmd_pulse, 3'b001);
                chk("press_e6_pls_hi", bif_hi.o_cmd_pulse, 3'b001);
            end
            if (e == 7) chk("press_e7_pls", bif_lo.o_cmd_pulse, 3'b000);
        end
        for (int e = 0; e < 5; e++) begin
            cycle(3'b001);
            chk("hold_lvl", bif_lo.o_btn_level, 3'b001);
            chk("hold_pls", bif_lo.o_cmd_pulse, 3'b000);
        end

        // Release latency, no strobe.
        for (int e = 1; e <= 6; e++) begin
            cycle(3'b000);
            if (e == 5) chk("rel_e5_lvl", bif_lo.o_btn_level, 3'b001);
            if (e == 6) chk("rel_e6_lvl", bif_lo.o_btn_level, 3'b000);
            chk("rel_pls", bif_lo.o_cmd_pulse, 3'b000);
        end
        idle(3);

        // Glitch of D-1 cycles is rejected; D cycles is accepted once.
        npulse = 0;
        for (int e = 0; e < 3; e++) cycle(3'b001);
        for (int e = 0; e < 8; e++) begin
            cycle(3'b000);
            if (bif_lo.o_cmd_pulse[0]) npulse++;
            chk("glitch_lvl", bif_lo.o_btn_level, 3'b000);
        end
        chk("glitch_npulse", 3'(npulse), 3'd0);
        npulse = 0;
        for (int e = 0; e < 4; e++) begin
            cycle(3'b001);
            if (bif_lo.o_cmd_pulse[0]) npulse++;
        end
        for (int e = 0; e < 12; e++) begin
            cycle(3'b000);
            if (bif_lo.o_cmd_pulse[0]) npulse++;
        end
        chk("d_width_npulse", 3'(npulse), 3'd1);
        idle(4);

        // Bounce train then steady press.
        npulse = 0;
        for (int e = 0; e < 10; e++) begin
            cycle((e % 2 == 0) ? 3'b001 : 3'b000);
            if (bif_lo.o_cmd_pulse[0]) npulse++;
        end
        for (int e = 1; e <= 8; e++) begin
            cycle(3'b001);
            if (bif_lo.o_cmd_pulse[0]) npulse++;
            if (e == 6) chk("bounce_e6_pls", bif_lo.o_cmd_pulse, 3'b001);
        end
        chk("bounce_npulse", 3'(npulse), 3'd1);
        idle(8);

        // Coincident presses on channels 1 and 2.
        for (int e = 1; e <= 7; e++) begin
            cycle(3'b110);
            if (e == 6) chk("multi_e6_pls", bif_lo.o_cmd_pulse, 3'b110);
            if (e == 7) chk("multi_e7_pls", bif_lo.o_cmd_pulse, 3'b000);
        end
        idle(8);

        // Reset with button held: cleared at once, fresh press afterwards.
        for (int e = 0; e < 8; e++) cycle(3'b001);
        chk("pre_rst_lvl", bif_lo.o_btn_level, 3'b001);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("in_rst_lvl", bif_lo.o_btn_level, 3'b000);
        chk("in_rst_lvl_hi", bif_hi.o_btn_level, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        chk("in_rst_pls", bif_lo.o_cmd_pulse, 3'b000);
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            cycle(3'b001);
            if (e == 5) chk("rst_e5_lvl", bif_lo.o_btn_level, 3'b000);
            if (e == 6) chk("rst_e6_pls", bif_lo.o_cmd_pulse, 3'b001);
        end

        // Released during reset: no strobe afterwards.
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        press = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        npulse = 0;
        for (int e = 0; e < 10; e++) begin
            cycle(3'b000);
            if (bif_lo.o_cmd_pulse != '0) npulse++;
        end
        chk("rst_release_npulse", 3'(npulse), 3'd0);

        // Random pad activity with occasional resets.
        for (int e = 0; e < 600; e++) begin
            logic [N-1:0] pr;
            pr = press;
            for (int c = 0; c < int'(N); c++)
                if ($urandom_range(0, 4) == 0) pr[c] = ~pr[c];
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                model_reset();
                @(posedge clk);
                #1;
                chk("rnd_rst_lvl", bif_lo.o_btn_level, '0);
                rst_n = 1'b1;
            end
            cycle(pr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
